// File: rtl/operand_uart_loader.sv
// operand_uart_loader: 8N1 UART receiver that assembles 8-byte big-endian operand frames and launches a multiply.
// Latency: rrf_a/rrf_b, mult_start and busy update together one clk after the internal strobe of the 8th byte.
// Backpressure: none on rx; bytes arriving while busy are dropped and flagged as overrun.
module operand_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        mult_done,
  output logic [31:0] rrf_a,
  output logic [31:0] rrf_b,
  output logic        mult_start,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2) - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {LD_COLLECT, LD_WAIT_DONE} ld_state_e;

  // ---------------- synchronizer and start-edge qualification ----------------
  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  logic       armed_q;
  logic [1:0] settle_q;
  logic       rx_fall;

  // two-flop synchronizer plus one history flop for edge detection; all idle high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // after reset, wait for the synchronizer to flush and the line to be seen high before
  // accepting a falling edge, so a line held low through reset is not taken as a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else if (settle_q != 2'd2) begin
      settle_q <= settle_q + 2'd1;
    end else if (rx_sync_q) begin
      armed_q <= 1'b1;
    end
  end

  assign rx_fall = armed_q & rx_prev_q & ~rx_sync_q;

  // ---------------- receiver FSM ----------------
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          byte_vld_q, stop_err_q, frame_err_q;
  logic          half_tick, bit_tick;

  // receiver state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  // receiver next-state: mid-start check, 8 data samples, one stop sample
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (half_tick) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && (bit_idx_q == 3'd7)) rx_state_d = RX_STOP;
      RX_STOP:  if (bit_tick) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // receiver sample strobes: half a bit into the start bit, then every full bit period
  always_comb begin
    half_tick = (rx_state_q == RX_START) && (clk_cnt_q == HALF_LAST);
    bit_tick  = ((rx_state_q == RX_DATA) || (rx_state_q == RX_STOP)) && (clk_cnt_q == BIT_LAST);
  end

  // receiver datapath: bit timer, LSB-first shifter, byte strobe and stop-bit error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      byte_vld_q  <= 1'b0;
      stop_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      stop_err_q <= 1'b0;
      if ((rx_state_q == RX_IDLE) || half_tick || bit_tick) clk_cnt_q <= '0;
      else                                                  clk_cnt_q <= clk_cnt_q + CW'(1);
      if (half_tick) bit_idx_q <= 3'd0;
      if (bit_tick && (rx_state_q == RX_DATA)) begin
        shift_q   <= {rx_sync_q, shift_q[7:1]};
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if (bit_tick && (rx_state_q == RX_STOP)) begin
        if (rx_sync_q) begin
          byte_vld_q <= 1'b1;
        end else begin
          stop_err_q  <= 1'b1;
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  // ---------------- loader FSM ----------------
  ld_state_e     ld_state_q, ld_state_d;
  logic [2:0]    byte_cnt_q;
  logic [55:0]   frame_q;   // first seven bytes; the eighth comes straight from the receiver
  logic [TW-1:0] idle_q;
  logic [31:0]   rrf_a_q, rrf_b_q;
  logic          mult_start_q, busy_q, overrun_q;
  logic          accept_en, load_en, drop_en, timeout_hit;

  // loader state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ld_state_q <= LD_COLLECT;
    else       ld_state_q <= ld_state_d;
  end

  // loader next-state: full frame starts a multiply, completion returns to collecting
  always_comb begin
    ld_state_d = ld_state_q;
    case (ld_state_q)
      LD_COLLECT:   if (byte_vld_q && (byte_cnt_q == 3'd7)) ld_state_d = LD_WAIT_DONE;
      LD_WAIT_DONE: if (mult_done) ld_state_d = LD_COLLECT;
      default:      ld_state_d = LD_COLLECT;
    endcase
  end

  // loader control decodes
  always_comb begin
    accept_en   = (ld_state_q == LD_COLLECT) && byte_vld_q;
    load_en     = accept_en && (byte_cnt_q == 3'd7);
    drop_en     = (ld_state_q == LD_WAIT_DONE) && byte_vld_q;
    timeout_hit = (ld_state_q == LD_COLLECT) && !byte_vld_q &&
                  (byte_cnt_q != 3'd0) && (idle_q == TO_LAST);
  end

  // loader datapath: frame assembly, operand load, busy/overrun tracking and inter-byte timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q   <= 3'd0;
      frame_q      <= 56'd0;
      idle_q       <= '0;
      rrf_a_q      <= 32'd0;
      rrf_b_q      <= 32'd0;
      mult_start_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      mult_start_q <= load_en;
      if (accept_en) frame_q <= {frame_q[47:0], shift_q};
      if (load_en) begin
        rrf_a_q <= frame_q[55:24];
        rrf_b_q <= {frame_q[23:0], shift_q};
      end
      // a bad stop bit or an idle gap abandons the partial frame
      if (load_en || stop_err_q || timeout_hit) byte_cnt_q <= 3'd0;
      else if (accept_en)                       byte_cnt_q <= byte_cnt_q + 3'd1;
      if (accept_en || timeout_hit || (ld_state_q != LD_COLLECT) || (byte_cnt_q == 3'd0))
        idle_q <= '0;
      else
        idle_q <= idle_q + TW'(1);
      if (load_en)                                      busy_q <= 1'b1;
      else if ((ld_state_q == LD_WAIT_DONE) && mult_done) busy_q <= 1'b0;
      if (drop_en) overrun_q <= 1'b1;
    end
  end

  assign rrf_a      = rrf_a_q;
  assign rrf_b      = rrf_b_q;
  assign mult_start = mult_start_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_operand_uart_loader.sv
// Bench for operand_uart_loader: UART byte driver, frame-level reference model and mult_start scoreboard.
// Expected operands are queued when a frame's bytes are issued; a monitor pops them on each mult_start.
// Bus stall is not applicable; busy/overrun behaviour is exercised directly.
module tb_operand_uart_loader;
  localparam int CPB = 8;
  localparam int TO  = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        mult_done;
  logic [31:0] rrf_a, rrf_b;
  logic        mult_start, busy, frame_err, overrun;

  operand_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx), .mult_done(mult_done),
    .rrf_a(rrf_a), .rrf_b(rrf_b), .mult_start(mult_start),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: bytes of the frame under assembly, pending expected loads, flags
  logic [7:0]  m_frame[$];
  logic [63:0] exp_q[$];
  logic        m_busy, m_frame_err, m_overrun;
  logic [31:0] m_a, m_b;
  int          m_loads = 0;
  int          seen_loads = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_frame.delete();
    m_busy = 1'b0; m_frame_err = 1'b0; m_overrun = 1'b0;
    m_a = 32'd0; m_b = 32'd0;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (m_busy) begin
      m_overrun = 1'b1;
    end else begin
      m_frame.push_back(b);
      if (m_frame.size() == 8) begin
        m_a = {m_frame[0], m_frame[1], m_frame[2], m_frame[3]};
        m_b = {m_frame[4], m_frame[5], m_frame[6], m_frame[7]};
        exp_q.push_back({m_a, m_b});
        m_loads++;
        m_busy = 1'b1;
        m_frame.delete();
      end
    end
  endfunction

  function automatic void model_stop_err();
    m_frame_err = 1'b1;
    m_frame.delete();
  endfunction

  // scoreboard monitor: every mult_start must match the oldest expected frame
  logic        prev_start = 1'b0;
  logic [63:0] mon_e;
  always @(negedge clk) begin
    if (!reset && mult_start) begin
      seen_loads++;
      check("mult_start_width", {63'd0, prev_start}, 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_mult_start: got pulse with rrf_a=%0h rrf_b=%0h expected none", rrf_a, rrf_b);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_rrf_a", {32'd0, rrf_a}, {32'd0, mon_e[63:32]});
        check("sb_rrf_b", {32'd0, rrf_b}, {32'd0, mon_e[31:0]});
        check("sb_busy_at_start", {63'd0, busy}, 64'd1);
      end
    end
    prev_start = mult_start;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) model_byte(b);
    else         model_stop_err();
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; tick(CPB);
    end
    rx = stop_ok; tick(CPB);
    rx = 1'b1;    tick(2 * CPB);
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send_byte(f[63 - 8*i -: 8], 1'b1);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rrf_a"},     {32'd0, rrf_a},     {32'd0, m_a});
    check({tag, "_rrf_b"},     {32'd0, rrf_b},     {32'd0, m_b});
    check({tag, "_busy"},      {63'd0, busy},      {63'd0, m_busy});
    check({tag, "_frame_err"}, {63'd0, frame_err}, {63'd0, m_frame_err});
    check({tag, "_overrun"},   {63'd0, overrun},   {63'd0, m_overrun});
  endtask

  task automatic pulse_done();
    check("busy_before_done", {63'd0, busy}, 64'd1);
    mult_done = 1'b1; tick(1);
    mult_done = 1'b0;
    m_busy = 1'b0;
    check("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic idle_timeout();
    tick(TO + 100);
    if (!m_busy) m_frame.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic [63:0] f;
    rx = 1'b1; mult_done = 1'b0; reset = 1'b1;
    model_reset();
    tick(3);
    check_outputs("reset");
    reset = 1'b0;
    tick(5);

    // mult_done while collecting must be ignored
    mult_done = 1'b1; tick(1); mult_done = 1'b0; tick(3);
    check_outputs("idle_done");

    // basic frame
    send_frame(64'h3F800000_40000000);
    tick(5);
    check_outputs("frame1");
    pulse_done();

    // partial frame abandoned by timeout, then a full frame
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle_timeout();
    send_frame(64'hC0A00000_3F000000);
    tick(5);
    check_outputs("frame2");
    pulse_done();

    // quarter-bit glitch: no byte, no flag
    rx = 1'b0; tick(CPB / 4); rx = 1'b1; tick(4 * CPB);
    check_outputs("glitch");

    // randomized frames, sometimes preceded by an abandoned partial frame
    for (int fr = 0; fr < 4; fr++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < int'($urandom_range(1, 5)); i++)
          send_byte(8'($urandom_range(0, 255)), 1'b1);
        idle_timeout();
      end
      f = {$urandom(), $urandom()};
      for (int i = 0; i < 8; i++) begin
        send_byte(f[63 - 8*i -: 8], 1'b1);
        tick($urandom_range(1, 60));
      end
      tick(3);
      check_outputs("rand_frame");
      tick($urandom_range(1, 20));
      pulse_done();
    end

    // bad stop bit clears the partial frame and sets frame_err
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h55, 1'b0);
    tick(5);
    check_outputs("stop_err");
    send_frame(64'h41200000_C1200000);
    tick(5);
    check_outputs("after_stop_err");

    // byte while busy is dropped
    send_byte(8'hAA, 1'b1);
    tick(5);
    check_outputs("overrun");

    // byte strobe and mult_done in the same cycle while busy
    found = 1'b0;
    fork
      send_byte(8'hAA, 1'b1);
      begin
        for (int k = 0; k < 200; k++) begin
          @(posedge clk); #1;
          if (dut.byte_vld_q) begin found = 1'b1; break; end
        end
        check("byte_strobe_seen", {63'd0, found}, 64'd1);
        if (found) begin
          mult_done = 1'b1;
          @(posedge clk); #1;
          mult_done = 1'b0;
        end
      end
    join
    m_busy = 1'b0;
    tick(3);
    check_outputs("overrun_with_done");
    send_frame(64'h3E800000_42C80000);
    tick(5);
    check_outputs("after_overrun");
    pulse_done();

    // reset in the middle of the 5th byte, with the line held low through reset release
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    fork
      send_byte(8'h00, 1'b1);
      begin
        tick(30);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_reset");
        tick(3);
        reset = 1'b0;
      end
    join
    tick(5);
    check_outputs("post_reset_idle");
    send_frame(64'hBF800000_40490FDB);
    tick(5);
    check_outputs("post_reset_frame");
    pulse_done();

    tick(20);
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("load_count", 64'(seen_loads), 64'(m_loads));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_uart_loader.md
OPERAND_UART_LOADER -- requirements
Module: operand_uart_loader

Interface
REQ-001: Parameter CLKS_PER_BIT, default 868, is the number of clk cycles per UART bit (100 MHz clock, 115200 baud); minimum 4.
REQ-002: Parameter TIMEOUT_CLKS, default 10_000_000, is the idle limit in clk cycles between bytes of one operand frame.
REQ-003: clk  input  1  single system clock; all logic is on the rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: rx  input  1  UART serial line, idle high, 8N1, LSB first; asynchronous to clk.
REQ-006: mult_done  input  1  multiplier completion pulse, one clk wide.
REQ-007: rrf_a  output  32  operand A, IEEE-754 single precision.
REQ-008: rrf_b  output  32  operand B, IEEE-754 single precision.
REQ-009: mult_start  output  1  one-clk pulse requesting a multiply of rrf_a and rrf_b.
REQ-010: busy  output  1  high from the mult_start pulse until mult_done is received.
REQ-011: frame_err  output  1  sticky flag: a stop bit was sampled low.
REQ-012: overrun  output  1  sticky flag: a byte was dropped while busy.

Function
REQ-013: rx is passed through a 2-flop synchronizer; all receiver decisions use the synchronized value only.
REQ-014: Receiver FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge of rx.
REQ-015: START: wait CLKS_PER_BIT/2 cycles (integer division), then sample rx.
- rx low -> DATA.
- rx high -> IDLE (glitch); no byte and no flag.
REQ-016: DATA: sample 8 bits, one every CLKS_PER_BIT cycles, LSB first, then go to STOP.
REQ-017: STOP: sample rx CLKS_PER_BIT cycles after the last data bit, then go to IDLE.
- rx high -> one-cycle internal byte_valid pulse in the next cycle.
- rx low -> set frame_err, discard the byte, clear the frame byte count.
REQ-018: Loader FSM states: COLLECT, WAIT_DONE.
- COLLECT holds a 3-bit byte count (0..7) and a 64-bit shift register.
REQ-019: Frame format: 8 bytes, big-endian, A[31:24], A[23:16], A[15:8], A[7:0], then B[31:24] .. B[7:0].
REQ-020: COLLECT, on byte_valid: shift the byte in and increment the count.
REQ-021: On the 8th byte_valid, in the same cycle:
- rrf_a and rrf_b load the assembled values.
- mult_start pulses for exactly one cycle.
- busy rises.
- FSM -> WAIT_DONE, count -> 0.
REQ-022: rrf_a and rrf_b change only at REQ-021; partial frames never disturb them.
REQ-023: WAIT_DONE, on mult_done: busy falls in the next cycle; FSM -> COLLECT.
REQ-024: WAIT_DONE, on byte_valid: drop the byte and set overrun.
REQ-025: byte_valid and mult_done in the same cycle while in WAIT_DONE: the byte is dropped, overrun is set, and the FSM still returns to COLLECT.
REQ-026: mult_done in COLLECT is ignored.
REQ-027: Timeout: in COLLECT with count nonzero, an idle counter reloads on every byte_valid.
- After TIMEOUT_CLKS cycles with no byte, count -> 0 and the partial frame is discarded; no flag.
REQ-028: The receiver keeps running in every loader state, so no byte in flight is lost to a loader state change.

Reset
REQ-029: While reset is high (asynchronous assertion):
- outputs: rrf_a=0, rrf_b=0, mult_start=0, busy=0, frame_err=0, overrun=0.
- receiver in IDLE, loader in COLLECT, count=0, timers=0, synchronizer flops=1.
REQ-030: Reset in the middle of a byte or frame discards all partial data.
REQ-031: After deassertion, the receiver waits for a new falling edge; a line already low is not treated as a start bit until it returns high and falls again.

Verification
REQ-032: Send 3F 80 00 00 40 00 00 00 -> rrf_a=0x3F800000, rrf_b=0x40000000, exactly one mult_start pulse, busy=1; pulse mult_done -> busy=0 next cycle.
REQ-033: Send 3 bytes, idle longer than TIMEOUT_CLKS, then send C0 A0 00 00 3F 00 00 00 -> rrf_a=0xC0A00000, rrf_b=0x3F000000; no flags set.
REQ-034: Send byte 55 with stop bit low -> frame_err=1, count=0; then send 8 valid bytes -> new operands load and mult_start pulses.
REQ-035: While busy, send byte AA -> overrun=1, rrf_a/rrf_b unchanged, no mult_start; assert mult_done on the same cycle as that byte_valid -> busy=0 and the next frame loads normally.
REQ-036: Drive a 0.25-bit low glitch on rx -> no byte and no flag; assert reset mid-byte in the 5th byte -> all outputs 0, and the next full frame loads correctly.
REQ-037: mult_done while idle in COLLECT -> no state change and no output change.
